// File: rtl/alu_seq_pkg.sv
// Shared types and width defaults for the ALU command sequencer.
// Imported by the sequencer top and its command FIFO.
package alu_seq_pkg;

  localparam int DW_DEF   = 4;
  localparam int SELW_DEF = 5;
  localparam int CNTW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cmd_width(
    input int dw,
    input int selw
  );
    return 2 * dw + selw;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO holding {a, b, sel} entries.
// Push and pop in one cycle are both honoured.
module alu_cmd_fifo
  import alu_seq_pkg::*;
#(
  parameter int W     = cmd_width(DW_DEF, SELW_DEF),
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_wdata,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;

  logic w_push;
  logic w_pop;

  // Guard here as well so a stray request can never corrupt the pointers
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  assign o_full  = (r_cnt == CNT_FULL);
  assign o_empty = (r_cnt == '0);
  assign o_rdata = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Feeds queued operand/opcode commands to an external 4-bit ALU one
// at a time and returns captured results over a valid/ready port.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DW         = DW_DEF,
  parameter int SELW       = SELW_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int ALU_LAT    = 1,
  parameter int CNTW       = CNTW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [DW-1:0]   cmd_a,
  input  logic [DW-1:0]   cmd_b,
  input  logic [SELW-1:0] cmd_sel,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  output logic [SELW-1:0] alu_sel,
  input  logic [DW-1:0]   alu_o,
  input  logic            alu_cout,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [DW-1:0]   res_o,
  output logic            res_cout,
  output logic            res_zero,
  output logic            busy,
  output logic [CNTW-1:0] op_count
);

  localparam int CW = cmd_width(DW, SELW);
  localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [LW-1:0] LAT_M1 = LW'(ALU_LAT - 1);

  state_t        r_state;
  logic [LW-1:0] r_wait;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_wdata;
  logic [CW-1:0] w_rdata;
  logic          w_res_hs;

  assign cmd_ready = !rst && !w_full;
  assign w_push    = cmd_valid && cmd_ready;
  assign w_wdata   = {cmd_a, cmd_b, cmd_sel};
  assign w_res_hs  = res_valid && res_ready;

  // The head is consumed either from idle or straight out of a handshake
  assign w_pop = !w_empty &&
                 ((r_state == IDLE) ||
                  (r_state == DONE && w_res_hs));

  assign res_zero = (res_o == '0);
  assign busy     = (r_state != IDLE) || !w_empty;

  alu_cmd_fifo #(
    .W     (CW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_wait    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      res_o     <= '0;
      res_cout  <= 1'b0;
      res_valid <= 1'b0;
      op_count  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_pop) begin
            {alu_a, alu_b, alu_sel} <= w_rdata;
            r_wait  <= LAT_M1;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          if (r_wait == '0) begin
            res_o     <= alu_o;
            res_cout  <= alu_cout;
            res_valid <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_wait <= r_wait - LW'(1);
          end
        end
        DONE: begin
          if (w_res_hs) begin
            op_count  <= op_count + CNTW'(1);
            res_valid <= 1'b0;
            if (w_pop) begin
              {alu_a, alu_b, alu_sel} <= w_rdata;
              r_wait  <= LAT_M1;
              r_state <= EXEC;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: queue-based result model plus directed
// vectors; a second instance runs with a 3-cycle ALU latency.
module tb_alu_cmd_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_a = '0;
  logic [3:0] cmd_b = '0;
  logic [4:0] cmd_sel = '0;
  logic [3:0] alu_a, alu_b, alu_o;
  logic [4:0] alu_sel;
  logic       alu_cout;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [3:0] res_o;
  logic       res_cout, res_zero, busy;
  logic [7:0] op_count;

  assign {alu_cout, alu_o} = {1'b0, alu_a} + {1'b0, alu_b};

  alu_cmd_sequencer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_o(alu_o), .alu_cout(alu_cout),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_o(res_o), .res_cout(res_cout), .res_zero(res_zero),
    .busy(busy), .op_count(op_count)
  );

  logic       cmd_valid2 = 1'b0;
  logic       cmd_ready2;
  logic [3:0] cmd_a2 = '0;
  logic [3:0] cmd_b2 = '0;
  logic [4:0] cmd_sel2 = '0;
  logic [3:0] alu_a2, alu_b2, alu_o2;
  logic [4:0] alu_sel2;
  logic       alu_cout2;
  logic       res_valid2;
  logic       res_ready2 = 1'b0;
  logic [3:0] res_o2;
  logic       res_cout2, res_zero2, busy2;
  logic [7:0] op_count2;
  logic       glitch = 1'b0;
  logic [4:0] sum2;

  assign sum2      = {1'b0, alu_a2} + {1'b0, alu_b2};
  assign alu_o2    = glitch ? 4'hF : sum2[3:0];
  assign alu_cout2 = glitch ? 1'b1 : sum2[4];

  alu_cmd_sequencer #(.ALU_LAT(3)) dut2 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_a(cmd_a2), .cmd_b(cmd_b2), .cmd_sel(cmd_sel2),
    .alu_a(alu_a2), .alu_b(alu_b2), .alu_sel(alu_sel2),
    .alu_o(alu_o2), .alu_cout(alu_cout2),
    .res_valid(res_valid2), .res_ready(res_ready2),
    .res_o(res_o2), .res_cout(res_cout2), .res_zero(res_zero2),
    .busy(busy2), .op_count(op_count2)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0] o;
    logic       c;
  } exp_t;

  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b);
    exp_t r;
    int s;
    s = int'(a) + int'(b);
    r.o = 4'(s % 16);
    r.c = (s >= 16);
    return r;
  endfunction

  exp_t q[$];
  int   mcount = 0;
  bit   en = 1'b0;

  // Pending = accepted but not yet consumed; busy must track it exactly
  always @(negedge clk) begin
    if (en) begin
      chk("busy", busy, q.size() != 0);
      chk("op_count", op_count, mcount % 256);
      if (q.size() == 0) begin
        chk("res_valid_idle", res_valid, 0);
      end else if (res_valid) begin
        chk("res_o", res_o, q[0].o);
        chk("res_cout", res_cout, q[0].c);
        chk("res_zero", res_zero, q[0].o == 4'h0);
      end
      if (rst) begin
        q.delete();
        mcount = 0;
      end else begin
        if (res_valid && res_ready && q.size() != 0) begin
          void'(q.pop_front());
          mcount++;
        end
        if (cmd_valid && cmd_ready) begin
          q.push_back(model(cmd_a, cmd_b));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] b,
                      input logic [4:0] s);
    int n;
    n = 0;
    cmd_a = a;
    cmd_b = b;
    cmd_sel = s;
    cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_res(input string nm, input logic [3:0] o,
                          input logic c, input logic z);
    int n;
    n = 0;
    @(negedge clk);
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_valid"}, res_valid, 1);
    chk({nm, "_o"}, res_o, o);
    chk({nm, "_cout"}, res_cout, c);
    chk({nm, "_zero"}, res_zero, z);
    step();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    step();
    step();
    en = 1'b1;
    smp();
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_sel", alu_sel, 0);
    chk("rst_res_o", res_o, 0);
    chk("rst_res_cout", res_cout, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    step();
    rst = 1'b0;
    smp();
    chk("post_rst_cmd_ready", cmd_ready, 1);

    // single op: 9 + 8 = 0x11
    step();
    push(4'h9, 4'h8, 5'h00);
    smp();
    chk("t1_valid_t1", res_valid, 0);
    chk("t1_busy", busy, 1);
    step();
    smp();
    chk("t1_alu_a", alu_a, 4'h9);
    chk("t1_alu_b", alu_b, 4'h8);
    chk("t1_alu_sel", alu_sel, 5'h00);
    chk("t1_valid_t2", res_valid, 0);
    step();
    res_ready = 1'b1;
    smp();
    chk("t1_valid_t3", res_valid, 1);
    chk("t1_res_o", res_o, 4'h1);
    chk("t1_cout", res_cout, 1);
    chk("t1_zero", res_zero, 0);
    step();
    res_ready = 1'b0;
    smp();
    chk("t1_op_count", op_count, 1);
    chk("t1_valid_after", res_valid, 0);
    chk("t1_alu_hold", alu_a, 4'h9);

    // fill: one op parked in DONE plus four queued
    step();
    for (int i = 1; i <= 5; i++) push(4'(i), 4'h0, 5'h00);
    smp();
    chk("t2_full_ready", cmd_ready, 0);
    chk("t2_valid", res_valid, 1);
    chk("t2_res_o", res_o, 4'h1);
    repeat (3) begin
      step();
      smp();
    end
    chk("t2_hold_o", res_o, 4'h1);
    chk("t2_hold_ready", cmd_ready, 0);
    step();
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      smp();
      chk("t2_seq_valid", res_valid, 1);
      chk("t2_seq_o", res_o, 4'(k + 1));
      step();
      if (k < 4) begin
        smp();
        chk("t2_gap_valid", res_valid, 0);
        step();
      end
    end
    res_ready = 1'b0;
    smp();
    chk("t2_busy_end", busy, 0);
    chk("t2_op_count", op_count, 6);

    // 8 + 8 wraps to zero with carry
    step();
    push(4'h8, 4'h8, 5'h00);
    wait_res("t3", 4'h0, 1'b1, 1'b1);

    // latency-3 instance ignores early ALU output
    step();
    cmd_a2 = 4'h2;
    cmd_b2 = 4'h3;
    cmd_sel2 = 5'h03;
    cmd_valid2 = 1'b1;
    smp();
    chk("t4_cmd_ready", cmd_ready2, 1);
    step();
    cmd_valid2 = 1'b0;
    step();
    glitch = 1'b1;
    smp();
    chk("t4_alu_a_c0", alu_a2, 4'h2);
    chk("t4_alu_b_c0", alu_b2, 4'h3);
    chk("t4_alu_sel_c0", alu_sel2, 5'h03);
    chk("t4_valid_c0", res_valid2, 0);
    step();
    smp();
    chk("t4_alu_a_c1", alu_a2, 4'h2);
    chk("t4_valid_c1", res_valid2, 0);
    step();
    glitch = 1'b0;
    smp();
    chk("t4_alu_b_c2", alu_b2, 4'h3);
    chk("t4_valid_c2", res_valid2, 0);
    step();
    smp();
    chk("t4_valid", res_valid2, 1);
    chk("t4_res_o", res_o2, 4'h5);
    chk("t4_cout", res_cout2, 0);
    step();
    res_ready2 = 1'b1;
    step();
    res_ready2 = 1'b0;
    smp();
    chk("t4_op_count", op_count2, 1);
    chk("t4_valid_after", res_valid2, 0);

    // reset while the second op executes with two still queued
    step();
    for (int i = 1; i <= 4; i++) push(4'(i), 4'h2, 5'h00);
    n = 0;
    smp();
    while (!res_valid && n < 50) begin
      smp();
      n++;
    end
    chk("t5_first_valid", res_valid, 1);
    step();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    rst = 1'b1;
    smp();
    chk("t5_exec_alu_a", alu_a, 4'h2);
    chk("t5_exec_valid", res_valid, 0);
    chk("t5_rst_ready", cmd_ready, 0);
    step();
    rst = 1'b0;
    smp();
    chk("t5_valid", res_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_op_count", op_count, 0);
    chk("t5_cmd_ready", cmd_ready, 1);
    chk("t5_alu_a", alu_a, 0);
    repeat (8) begin
      step();
      smp();
      chk("t5_no_result", res_valid, 0);
    end

    // 256 ops wrap the counter back to zero
    step();
    res_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      push(4'(i), 4'(i >> 4), 5'(i));
    end
    n = 0;
    smp();
    while (busy && n < 50) begin
      smp();
      n++;
    end
    chk("t6_idle", busy, 0);
    chk("t6_op_count", op_count, 0);
    chk("t6_model_count", mcount, 256);
    res_ready = 1'b0;

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Upstream feeder for the 4-bit ALU.
- Buffers operand/opcode commands from a valid/ready source in a small FIFO.
- Issues one command at a time by driving alu_a, alu_b and alu_sel (maps to s4..s0) stable for ALU_LAT cycles, then captures alu_o/alu_cout.
- Returns each result on a valid/ready result port, with a zero flag and a completed-op counter.

Parameters:
- DW, 4: operand/result width.
- SELW, 5: opcode width; alu_sel[4:0] = {s4,s3,s2,s1,s0}.
- FIFO_DEPTH, 4: command FIFO entries (power of 2, ≥2).
- ALU_LAT, 1: cycles operands are held before sampling the ALU (≥1).
- CNTW, 8: op counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept.
- cmd_a  in  DW  operand a.
- cmd_b  in  DW  operand b.
- cmd_sel  in  SELW  opcode.
- alu_a  out  DW  to ALU a.
- alu_b  out  DW  to ALU b.
- alu_sel  out  SELW  to ALU s4..s0.
- alu_o  in  DW  ALU result.
- alu_cout  in  1  ALU carry.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts.
- res_o  out  DW  captured result.
- res_cout  out  1  captured carry.
- res_zero  out  1  res_o == 0.
- busy  out  1  state != IDLE or FIFO non-empty.
- op_count  out  CNTW  results consumed; wraps.

Behaviour:
- Reset (rst sampled high at an edge):
  - FIFO emptied; state IDLE.
  - alu_a, alu_b, alu_sel, res_o, res_cout, op_count all 0.
  - res_valid = 0, busy = 0.
  - cmd_ready = 0 while rst is high, then = !full.
  - Reset mid-operation discards the in-flight op and all queued commands; no res_valid is produced for them.
- Command FIFO:
  - Push when cmd_valid && cmd_ready.
  - cmd_ready = !full (registered state only, no fall-through); a push when full is impossible.
  - A pop and a push in the same cycle are both honoured; count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into the operand regs, load wait counter = ALU_LAT-1, go to EXEC.
  - EXEC: alu_a/alu_b/alu_sel come from the operand regs (registered outputs, stable throughout). If counter == 0, capture alu_o into res_o and alu_cout into res_cout, set res_valid, go to DONE. Otherwise decrement the counter.
  - DONE: res_valid held high, res_o/res_cout held stable until res_valid && res_ready.
    - On that handshake, op_count increments.
    - If the FIFO is non-empty in the same cycle, pop and go straight to EXEC (back-to-back); else go to IDLE with res_valid = 0.
- Outputs between ops: alu_* hold their last issued values (no return to 0).
- Latency: command accepted at cycle T into an empty, idle block → EXEC at T+2 → res_valid at T+2+ALU_LAT.
- Throughput: with res_ready tied high, one result per ALU_LAT+1 cycles.
- Arithmetic: op_count wraps 2^CNTW-1 → 0 without flag. res_zero is combinational from res_o.
- res_ready high while res_valid is low has no effect.

Decomposition:
- Shared package alu_seq_pkg:
  - State encoding IDLE=2'd0, EXEC=2'd1, DONE=2'd2.
  - Width constants DW, SELW, CNTW defaults.
- One sub-module: alu_cmd_fifo, synchronous FIFO of width 2*DW+SELW with push/pop/full/empty.
- The FSM, wait counter and result registers stay in the top module.

Test Plan:
- Setup for all scenarios: bench ALU stub computes {alu_cout, alu_o} = alu_a + alu_b.
- Reset then single cmd a=4'h9, b=4'h8, sel=5'b00000 at T → alu_a=9 and alu_b=8 at T+2; res_valid at T+3 with res_o=4'h1, res_cout=1, res_zero=0; op_count=1 after the handshake.
- Push 5 cmds back-to-back (a=1..5, b=0) with res_ready=0 → cmd_ready low after the 4th queued push plus the one in EXEC; result stays at res_o=1; raise res_ready → results 1,2,3,4,5 in order, one every 2 cycles.
- a=4'h8, b=4'h8 → res_o=0, res_cout=1, res_zero=1.
- ALU_LAT=3 build, a=2, b=3 → alu_* stable 3 cycles; stub output glitched to 4'hF in the first 2 EXEC cycles is not captured; res_o=5.
- Assert rst during EXEC with 2 cmds queued → next cycle state IDLE, res_valid=0, FIFO empty, op_count=0; no result appears afterwards.
- Issue 256 ops with res_ready=1 → op_count wraps to 0.
